hazard_flush_ctrl: RTL and testbench

HAZARD_FLUSH_CTRL -- requirements
Module: hazard_flush_ctrl

---
 rtl/hazard_flush_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_flush_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard controller: resolves reset, memory wait, taken branch and load-use
// hazards into stall, flush and freeze controls, with stall and memory-wait monitors.
module hazard_flush_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_rd,
  input  logic [4:0]  IFID_rs1,
  input  logic [4:0]  IFID_rs2,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        Flushout,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic        pipe_freeze,
  output logic [1:0]  state,
  output logic [31:0] stall_cnt,
  output logic        timeout
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } state_e;

  localparam logic [7:0] WaitMax = 8'(MAX_WAIT);

  state_e      r_state, w_state_next;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_stall_cnt;
  logic        r_timeout;
  logic        w_load_use;

  assign w_load_use = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                      ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));

  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    Flushout     = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Flush  = 1'b0;
    pipe_freeze  = 1'b0;
    w_state_next = StRun;
    if (reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      Flushout    = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else if (mem_busy) begin
      // A pending branch stays in the frozen EX/MEM stage and is taken once memory is ready.
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      pipe_freeze  = 1'b1;
      w_state_next = StMemWait;
    end else if (branch_taken) begin
      Flushout     = 1'b1;
      IDEX_Flush   = 1'b1;
      EXMEM_Flush  = 1'b1;
      w_state_next = StFlush;
    end else if (w_load_use && (r_state != StFlush)) begin
      // After a flush IF/ID holds a zeroed instruction, so any match is spurious.
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Flush   = 1'b1;
      w_state_next = StLuStall;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_stall_cnt <= 32'd0;
      r_wait_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (!PCWrite && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (mem_busy) begin
        if (r_wait_cnt != WaitMax) begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
        end
        if (r_wait_cnt == WaitMax) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_wait_cnt <= 8'd0;
      end
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: directed hazard scenarios then random traffic,
// all checked against a cycle model built from the hazard priority rules.
module tb_hazard_flush_ctrl;

  localparam int unsigned MaxWait = 4;

  logic        clk = 1'b0;
  logic        reset, IDEX_MemRead, branch_taken, mem_busy;
  logic [4:0]  IDEX_rd, IFID_rs1, IFID_rs2;
  logic        PCWrite, IFID_Write, Flushout, IDEX_Flush, EXMEM_Flush, pipe_freeze, timeout;
  logic [1:0]  state;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: last action code, stall total, length of current busy run, sticky timeout.
  int              m_state = 0;
  longint unsigned m_stall = 0;
  int              m_run   = 0;
  bit              m_to    = 1'b0;

  hazard_flush_ctrl #(.MAX_WAIT(MaxWait)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_rd      (IDEX_rd),
    .IFID_rs1     (IFID_rs1),
    .IFID_rs2     (IFID_rs2),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .PCWrite      (PCWrite),
    .IFID_Write   (IFID_Write),
    .Flushout     (Flushout),
    .IDEX_Flush   (IDEX_Flush),
    .EXMEM_Flush  (EXMEM_Flush),
    .pipe_freeze  (pipe_freeze),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic br, input logic busy);
    reset        = rst;
    IDEX_MemRead = mr;
    IDEX_rd      = rd;
    IFID_rs1     = rs1;
    IFID_rs2     = rs2;
    branch_taken = br;
    mem_busy     = busy;
  endtask

  // One cycle: check combinational controls mid-cycle, then registered state after the edge.
  task automatic step();
    bit         lu;
    logic [5:0] ec;
    int         nx;
    @(negedge clk);
    lu = IDEX_MemRead && (IDEX_rd != 0) && (IDEX_rd == IFID_rs1 || IDEX_rd == IFID_rs2);
    // order: PCWrite, IFID_Write, Flushout, IDEX_Flush, EXMEM_Flush, pipe_freeze
    if (reset) begin
      ec = 6'b001110; nx = 0;
    end else if (mem_busy) begin
      ec = 6'b000001; nx = 2;
    end else if (branch_taken) begin
      ec = 6'b111110; nx = 3;
    end else if (lu && m_state != 3) begin
      ec = 6'b000100; nx = 1;
    end else begin
      ec = 6'b110000; nx = 0;
    end
    check_eq("ctrl", 32'({PCWrite, IFID_Write, Flushout, IDEX_Flush, EXMEM_Flush, pipe_freeze}),
             32'(ec));
    check_eq("flush_without_ifid_write", 32'(Flushout && !IFID_Write && !reset), 32'd0);
    @(posedge clk);
    #1;
    if (reset) begin
      m_state = 0; m_stall = 0; m_run = 0; m_to = 1'b0;
    end else begin
      m_state = nx;
      if (!ec[5] && m_stall != 64'hFFFF_FFFF) m_stall++;
      m_run = mem_busy ? m_run + 1 : 0;
      if (m_run > int'(MaxWait)) m_to = 1'b1;
    end
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("stall_cnt", stall_cnt, m_stall[31:0]);
    check_eq("timeout", 32'(timeout), 32'(m_to));
  endtask

  initial begin
    bit busy_prev = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_eq("reset_ctrl", 32'({PCWrite, IFID_Write, Flushout, IDEX_Flush, EXMEM_Flush,
                                pipe_freeze}), 32'b001110);
    step();
    step();
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_stall", stall_cnt, 32'd0);
    check_eq("reset_timeout", 32'(timeout), 32'd0);

    // Load-use on rs2
    drive(0, 1, 5, 1, 5, 0, 0);
    #1;
    check_eq("lu_pcw", 32'({PCWrite, IFID_Write, IDEX_Flush}), 32'b001);
    step();
    check_eq("lu_state", 32'(state), 32'd1);
    check_eq("lu_stall", stall_cnt, 32'd1);
    drive(0, 0, 5, 1, 5, 0, 0);
    #1;
    check_eq("lu_release_pcw", 32'(PCWrite), 32'd1);
    step();
    check_eq("lu_release_state", 32'(state), 32'd0);

    // x0 destination never stalls
    drive(0, 1, 0, 0, 3, 0, 0);
    #1;
    check_eq("x0_pcw", 32'(PCWrite), 32'd1);
    step();
    check_eq("x0_stall", stall_cnt, 32'd1);

    // Branch beats load-use; load-use ignored the cycle after
    drive(0, 1, 7, 7, 2, 1, 0);
    #1;
    check_eq("br_ctrl", 32'({PCWrite, Flushout, IDEX_Flush, EXMEM_Flush}), 32'b1111);
    step();
    check_eq("br_state", 32'(state), 32'd3);
    drive(0, 1, 7, 7, 2, 0, 0);
    #1;
    check_eq("flush_ignores_lu", 32'({PCWrite, IDEX_Flush}), 32'b10);
    step();
    check_eq("flush_exit_state", 32'(state), 32'd0);

    // Branch held during a memory wait
    drive(0, 0, 0, 0, 0, 1, 1);
    #1;
    check_eq("br_busy_noflush", 32'(Flushout), 32'd0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    #1;
    check_eq("br_after_busy_flush", 32'(Flushout), 32'd1);
    step();

    // Memory wait with timeout
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      #1;
      check_eq("wait_freeze", 32'(pipe_freeze), 32'd1);
      step();
      if (i == 3) check_eq("timeout_not_yet", 32'(timeout), 32'd0);
      if (i == 4) check_eq("timeout_set", 32'(timeout), 32'd1);
    end
    check_eq("wait_stall6", stall_cnt, 32'd6);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check_eq("timeout_sticky", 32'(timeout), 32'd1);

    // Reset mid-wait
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    step();
    drive(1, 1, 3, 3, 3, 1, 1);
    #1;
    check_eq("rst_wait_ctrl", 32'({Flushout, PCWrite}), 32'b10);
    step();
    check_eq("rst_wait_state", 32'(state), 32'd0);
    check_eq("rst_wait_stall", stall_cnt, 32'd0);
    check_eq("rst_wait_timeout", 32'(timeout), 32'd0);

    // Random traffic with bursty memory waits
    for (int n = 0; n < 600; n++) begin
      logic b;
      b = busy_prev ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 5) == 0);
      busy_prev = b;
      drive(logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            logic'($urandom_range(0, 5) == 0), b);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
